serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub_pkg.sv | 13 +
 rtl/serial_add_sub_full_a_s.sv | 18 +
 rtl/serial_add_sub.sv | 97 +++++++++
 tb/tb_serial_add_sub.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and mode codes.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_full_a_s.sv
// Single-bit full adder/subtractor cell; mode selects add (0) or subtract (1).
module full_a_s (
    input  logic in1,
    input  logic in2,
    input  logic mode,
    input  logic carryin,
    output logic sum_diff,
    output logic carry_borr
);

    logic m;

    // Inverting in1 turns the majority carry into the borrow of in1-in2-cin.
    assign m          = mode ^ in1;
    assign sum_diff   = in1 ^ in2 ^ carryin;
    assign carry_borr = (m & in2) | (m & carryin) | (in2 & carryin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one full adder/subtractor cell reused per clock.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, res_sh_q;
    logic [WIDTH-1:0]   result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mode_q, cy_q, carry_q, ovf_q;
    logic               sum_bit, cy_bit, last_bit, ovf_bit;

    full_a_s u_cell (
        .in1        (a_sh_q[0]),
        .in2        (b_sh_q[0]),
        .mode       (mode_q),
        .carryin    (cy_q),
        .sum_diff   (sum_bit),
        .carry_borr (cy_bit)
    );

    assign last_bit = (state_q == StRun) && (cnt_q == CNT_W'(WIDTH - 1));

    // On the last bit the shift registers hold the operand sign bits and sum_bit is the result sign.
    assign ovf_bit = ((mode_q == MODE_SUB) ? (a_sh_q[0] ^ b_sh_q[0]) : ~(a_sh_q[0] ^ b_sh_q[0]))
                     & (sum_bit ^ a_sh_q[0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_ADD;
            cy_q     <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                a_sh_q <= a;
                b_sh_q <= b;
                mode_q <= mode;
                cy_q   <= 1'b0;
                cnt_q  <= '0;
            end else if (state_q == StRun) begin
                a_sh_q   <= a_sh_q >> 1;
                b_sh_q   <= b_sh_q >> 1;
                res_sh_q <= {sum_bit, res_sh_q[WIDTH-1:1]};
                cy_q     <= cy_bit;
                cnt_q    <= cnt_q + 1'b1;
                if (last_bit) begin
                    result_q <= {sum_bit, res_sh_q[WIDTH-1:1]};
                    carry_q  <= cy_bit;
                    ovf_q    <= ovf_bit;
                end
            end
        end
    end

    assign ready     = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub with WIDTH=8 plus a model-checked operand sweep.
module tb_serial_add_sub;

    localparam int unsigned WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst, start, mode;
    logic [7:0] a, b;
    logic       ready, busy, done, carry_out, overflow;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one operation, scramble inputs while it runs, check latency, outputs and pulse width.
    task automatic do_op(input string tag, input logic m, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        start = 1'b1; mode = m; a = x; b = y;
        @(negedge clk);
        start = 1'b0; mode = ~m; a = ~x; b = ~y;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_int({tag, " latency"}, n, WIDTH);
        check8({tag, " result"}, result, er);
        check1({tag, " carry"}, carry_out, ec);
        check1({tag, " ovf"}, overflow, eo);
        @(negedge clk);
        check1({tag, " done width"}, done, 1'b0);
        check1({tag, " ready after"}, ready, 1'b1);
    endtask

    initial begin
        int pulses;
        logic [7:0] x, y;
        logic       m;
        logic [8:0] s;
        logic       eo;

        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check1("rst ready", ready, 1'b1);
        check1("rst busy", busy, 1'b0);
        check1("rst done", done, 1'b0);
        check8("rst result", result, 8'h00);
        check1("rst carry", carry_out, 1'b0);
        check1("rst ovf", overflow, 1'b0);

        do_op("add 5a+3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
        do_op("sub 10-20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        do_op("add ff+01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        do_op("sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        // Start during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 8'h01; b = 8'h02;
        @(negedge clk);
        start = 1'b0;
        check1("run busy", busy, 1'b1);
        check1("run ready", ready, 1'b0);
        check8("outputs held in run", result, 8'h7F);
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) pulses++;
            if (done) check8("ignore result", result, 8'h03);
        end
        check_int("ignore pulses", pulses, 1);
        check1("ignore ready", ready, 1'b1);

        // Reset mid-RUN discards the operation.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 8'h33; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check1("midrst ready", ready, 1'b1);
        check1("midrst busy", busy, 1'b0);
        check8("midrst result", result, 8'h00);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_int("midrst no done", pulses, 0);
        do_op("sub 05-05", 1'b1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0);

        // Reset beats a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check1("rst+start ready", ready, 1'b1);
        @(negedge clk);
        check1("rst+start busy", busy, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            m = 1'($urandom);
            s = m ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
            eo = m ? ((x[7] != y[7]) && (s[7] != x[7])) : ((x[7] == y[7]) && (s[7] != x[7]));
            do_op("rand", m, x, y, s[7:0], s[8], eo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
